vga_timing_gen: RTL and testbench

Parametrised, run-time programmable raster timing generator for the VGA peripheral. It produces pixel/line counters, sync, blank, line/frame strobes and a frame counter, with a three-source maskable interrupt (hblank, vblank, line-compare) and per-cause clear. Horizontal and vertical timing registers are double-buffered and take effect only at frame wrap, so software can switch modes glitch-free. It replaces the fixed-mode generator in front of the pixel fetch and serialiser logic.

---
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync, blank, line/frame strobes,
// frame counter and a three-cause maskable interrupt. Horizontal and vertical
// timing registers are double-buffered and switch over at frame wrap.
module vga_timing_gen #(
   parameter int XW           = 11,
   parameter int YW           = 10,
   parameter int H_ACTIVE_DEF = 1024,
   parameter int H_SYNC_S_DEF = 1072,
   parameter int H_SYNC_E_DEF = 1176,
   parameter int H_TOTAL_DEF  = 1327,
   parameter int V_ACTIVE_DEF = 768,
   parameter int V_SYNC_S_DEF = 771,
   parameter int V_SYNC_E_DEF = 775,
   parameter int V_TOTAL_DEF  = 797
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [XW-1:0] cfg_wdata,
   input  logic [2:0]    irq_clear,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic          line_end,
   output logic          frame_end,
   output logic [7:0]    frame_cnt,
   output logic [2:0]    irq_cause,
   output logic          irq
);

   // Pending (software-visible) timing copies
   logic [XW-1:0] h_act_pend_r, h_ss_pend_r, h_se_pend_r, h_tot_pend_r;
   logic [YW-1:0] v_act_pend_r, v_ss_pend_r, v_se_pend_r, v_tot_pend_r;
   // Active timing copies used by the counters and decoders
   logic [XW-1:0] h_act_r, h_ss_r, h_se_r, h_tot_r;
   logic [YW-1:0] v_act_r, v_ss_r, v_se_r, v_tot_r;
   logic [YW-1:0] line_cmp_r;
   logic [4:0]    ctrl_r;

   logic [XW-1:0] x_r;
   logic [YW-1:0] y_r;
   logic [7:0]    frame_cnt_r;
   logic [2:0]    irq_cause_r;
   logic          hsync_r, vsync_r;

   logic          line_end_s, frame_end_s, hs_in_s, vs_in_s, blank_s;
   logic [2:0]    irq_set_s, irq_next_s;

   // Decode strobes, sync windows, blanking and interrupt set/clear from current state
   always_comb begin
      line_end_s  = (x_r == h_tot_r);
      frame_end_s = line_end_s && (y_r == v_tot_r);
      // An empty or inverted window (END <= START) can never match
      hs_in_s     = (x_r >= h_ss_r) && (x_r < h_se_r);
      vs_in_s     = (y_r >= v_ss_r) && (y_r < v_se_r);
      blank_s     = (x_r >= h_act_r) || (y_r >= v_act_r);
      irq_set_s   = 3'b000;
      irq_set_s[0] = (x_r == h_act_r) && ctrl_r[2];
      irq_set_s[1] = (x_r == '0) && (y_r == v_act_r) && ctrl_r[3];
      irq_set_s[2] = (x_r == '0) && (y_r == line_cmp_r) && ctrl_r[4];
      // Set has priority over a simultaneous clear
      irq_next_s  = (irq_cause_r & ~irq_clear) | irq_set_s;
   end

   // Software writes into the pending timing set, LINE_CMP and CTRL
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_act_pend_r <= XW'(H_ACTIVE_DEF);
         h_ss_pend_r  <= XW'(H_SYNC_S_DEF);
         h_se_pend_r  <= XW'(H_SYNC_E_DEF);
         h_tot_pend_r <= XW'(H_TOTAL_DEF);
         v_act_pend_r <= YW'(V_ACTIVE_DEF);
         v_ss_pend_r  <= YW'(V_SYNC_S_DEF);
         v_se_pend_r  <= YW'(V_SYNC_E_DEF);
         v_tot_pend_r <= YW'(V_TOTAL_DEF);
         line_cmp_r   <= '0;
         ctrl_r       <= 5'b00000;
      end else if (cfg_we) begin
         case (cfg_addr)
            4'd0:    h_act_pend_r <= cfg_wdata;
            4'd1:    h_ss_pend_r  <= cfg_wdata;
            4'd2:    h_se_pend_r  <= cfg_wdata;
            4'd3:    h_tot_pend_r <= cfg_wdata;
            4'd4:    v_act_pend_r <= cfg_wdata[YW-1:0];
            4'd5:    v_ss_pend_r  <= cfg_wdata[YW-1:0];
            4'd6:    v_se_pend_r  <= cfg_wdata[YW-1:0];
            4'd7:    v_tot_pend_r <= cfg_wdata[YW-1:0];
            4'd8:    line_cmp_r   <= cfg_wdata[YW-1:0];
            4'd9:    ctrl_r       <= cfg_wdata[4:0];
            default: ;
         endcase
      end
   end

   // Promote the pending timing set together with the counter wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_act_r <= XW'(H_ACTIVE_DEF);
         h_ss_r  <= XW'(H_SYNC_S_DEF);
         h_se_r  <= XW'(H_SYNC_E_DEF);
         h_tot_r <= XW'(H_TOTAL_DEF);
         v_act_r <= YW'(V_ACTIVE_DEF);
         v_ss_r  <= YW'(V_SYNC_S_DEF);
         v_se_r  <= YW'(V_SYNC_E_DEF);
         v_tot_r <= YW'(V_TOTAL_DEF);
      end else if (frame_end_s) begin
         h_act_r <= h_act_pend_r;
         h_ss_r  <= h_ss_pend_r;
         h_se_r  <= h_se_pend_r;
         h_tot_r <= h_tot_pend_r;
         v_act_r <= v_act_pend_r;
         v_ss_r  <= v_ss_pend_r;
         v_se_r  <= v_se_pend_r;
         v_tot_r <= v_tot_pend_r;
      end
   end

   // Pixel/line counters and completed-frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r         <= '0;
         y_r         <= '0;
         frame_cnt_r <= 8'd0;
      end else begin
         if (line_end_s) begin
            x_r <= '0;
            y_r <= frame_end_s ? '0 : (y_r + YW'(1));
         end else begin
            x_r <= x_r + XW'(1);
         end
         if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 8'd1;
         end
      end
   end

   // Registered sync outputs; XOR with the inverted polarity bit gives the idle level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_r <= 1'b0;
         vsync_r <= 1'b0;
      end else begin
         hsync_r <= hs_in_s ^ ~ctrl_r[0];
         vsync_r <= vs_in_s ^ ~ctrl_r[1];
      end
   end

   // Sticky interrupt causes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_cause_r <= 3'b000;
      end else begin
         irq_cause_r <= irq_next_s;
      end
   end

   assign x         = x_r;
   assign y         = y_r;
   assign hsync     = hsync_r;
   assign vsync     = vsync_r;
   assign blank     = blank_s;
   assign line_end  = line_end_s;
   assign frame_end = frame_end_s;
   assign frame_cnt = frame_cnt_r;
   assign irq_cause = irq_cause_r;
   assign irq       = |irq_cause_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. The DEF mode is shrunk to a 56x30 raster
// so that whole default frames fit into a short run.
module tb_vga_timing_gen;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [3:0]  cfg_addr;
   logic [10:0] cfg_wdata;
   logic [2:0]  irq_clear;
   logic [10:0] x;
   logic [9:0]  y;
   logic        hsync, vsync, blank, line_end, frame_end, irq;
   logic [7:0]  frame_cnt;
   logic [2:0]  irq_cause;

   int n_cmp = 0;
   int n_err = 0;

   vga_timing_gen #(
      .XW(11), .YW(10),
      .H_ACTIVE_DEF(40), .H_SYNC_S_DEF(44), .H_SYNC_E_DEF(48), .H_TOTAL_DEF(55),
      .V_ACTIVE_DEF(20), .V_SYNC_S_DEF(22), .V_SYNC_E_DEF(24), .V_TOTAL_DEF(29)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .irq_clear(irq_clear), .x(x), .y(y),
      .hsync(hsync), .vsync(vsync), .blank(blank), .line_end(line_end),
      .frame_end(frame_end), .frame_cnt(frame_cnt), .irq_cause(irq_cause), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [10:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   task automatic wait_xy(input string tag, input int tx, input int ty, input int bound);
      int n = 0;
      while (!((int'(x) == tx) && (int'(y) == ty)) && (n < bound)) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'((int'(x) == tx) && (int'(y) == ty)), 32'd1);
   endtask

   task automatic wait_frame_end(input string tag, input int bound);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_end && (n < bound));
      check_val(tag, 32'(frame_end), 32'd1);
   endtask

   task automatic count_line(output int n, input int bound);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!line_end && (n < bound));
   endtask

   task automatic count_frame(output int n, input int bound);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_end && (n < bound));
   endtask

   initial begin
      int         n;
      int         lows;
      logic [7:0] f0;
      logic [7:0] f1;
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 11'd0; irq_clear = 3'b000;
      repeat (2) @(negedge clk);

      // Reset state
      check_val("rst_x", 32'(x), 32'd0);
      check_val("rst_y", 32'(y), 32'd0);
      check_val("rst_fcnt", 32'(frame_cnt), 32'd0);
      check_val("rst_cause", 32'(irq_cause), 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      check_val("rst_hsync", 32'(hsync), 32'd0);
      check_val("rst_vsync", 32'(vsync), 32'd0);
      check_val("rst_blank", 32'(blank), 32'd0);
      check_val("rst_line_end", 32'(line_end), 32'd0);
      rst_n = 1'b1;

      // Shadowing: H_TOTAL written mid-frame must not shorten the current frame
      wait_xy("wait_x10", 10, 0, 100);
      cfg_write(4'd3, 11'd15);
      count_line(n, 100);
      check_val("shadow_old_total", 32'(x), 32'd55);
      count_line(n, 100);
      check_val("line_period_def", 32'(n), 32'd56);

      // Small mode, all interrupts enabled, LINE_CMP=2, active-high syncs
      cfg_write(4'd0, 11'd8);
      cfg_write(4'd1, 11'd10);
      cfg_write(4'd2, 11'd12);
      cfg_write(4'd4, 11'd4);
      cfg_write(4'd5, 11'd5);
      cfg_write(4'd6, 11'd6);
      cfg_write(4'd7, 11'd7);
      cfg_write(4'd8, 11'd2);
      cfg_write(4'd9, 11'h1f);
      cfg_write(4'd12, 11'd3);   // unmapped address, must be ignored
      wait_frame_end("fe_def", 2000);
      check_val("def_v_total", 32'(y), 32'd29);
      @(negedge clk);
      check_val("wrap_x", 32'(x), 32'd0);
      check_val("wrap_y", 32'(y), 32'd0);
      check_val("fcnt_1", 32'(frame_cnt), 32'd1);
      irq_clear = 3'b111;
      @(negedge clk);
      irq_clear = 3'b000;
      check_val("irq_clr_all", 32'(irq_cause), 32'd0);

      // hblank sets from x==8, visible one cycle later
      wait_xy("wait_8_0", 8, 0, 20);
      check_val("hblank_not_yet", 32'(irq_cause), 32'd0);
      @(negedge clk);
      check_val("hblank_set", 32'(irq_cause), 32'd1);
      check_val("blank_x9", 32'(blank), 32'd1);
      @(negedge clk);
      check_val("hs_x10", 32'(hsync), 32'd0);
      @(negedge clk);
      check_val("hs_x11", 32'(hsync), 32'd1);
      @(negedge clk);
      check_val("hs_x12", 32'(hsync), 32'd1);
      @(negedge clk);
      check_val("hs_x13", 32'(hsync), 32'd0);
      wait_xy("wait_15_0", 15, 0, 20);
      check_val("line_end_small", 32'(line_end), 32'd1);
      check_val("frame_end_mid", 32'(frame_end), 32'd0);

      // Set wins over a same-cycle clear, then a plain clear works
      wait_xy("wait_8_1", 8, 1, 20);
      irq_clear = 3'b001;
      @(negedge clk);
      check_val("set_wins", 32'(irq_cause), 32'd1);
      @(negedge clk);
      irq_clear = 3'b000;
      check_val("hblank_clr", 32'(irq_cause), 32'd0);

      wait_xy("wait_1_2", 1, 2, 40);
      check_val("line_set", 32'(irq_cause), 32'b100);
      check_val("blank_active", 32'(blank), 32'd0);
      check_val("irq_line", 32'(irq), 32'd1);
      wait_xy("wait_1_4", 1, 4, 40);
      check_val("vblank_set", 32'(irq_cause), 32'b111);
      check_val("blank_y4", 32'(blank), 32'd1);
      wait_xy("wait_1_5", 1, 5, 20);
      check_val("vs_high", 32'(vsync), 32'd1);
      wait_xy("wait_1_6", 1, 6, 20);
      check_val("vs_after", 32'(vsync), 32'd0);

      // Frame period and frame counter step
      wait_frame_end("fe_small", 200);
      f0 = frame_cnt;
      count_frame(n, 300);
      f1 = f0 + 8'd1;
      check_val("frame_period", 32'(n), 32'd128);
      check_val("fcnt_step", 32'(frame_cnt), 32'(f1));

      // Active-low syncs; disabling enables keeps pending causes
      cfg_write(4'd9, 11'd0);
      check_val("enable_off_keeps", 32'(irq_cause), 32'b111);
      wait_xy("wait_11_0", 11, 0, 20);
      check_val("hs_low_sync", 32'(hsync), 32'd0);
      wait_xy("wait_13_0", 13, 0, 20);
      check_val("hs_idle_high", 32'(hsync), 32'd1);
      wait_xy("wait_1_5b", 1, 5, 100);
      check_val("vs_low_sync", 32'(vsync), 32'd0);
      wait_xy("wait_1_6b", 1, 6, 20);
      check_val("vs_idle_high", 32'(vsync), 32'd1);
      irq_clear = 3'b111;
      @(negedge clk);
      irq_clear = 3'b000;

      // Degenerate sync window: END == START
      cfg_write(4'd2, 11'd10);
      wait_frame_end("fe_degen", 200);
      @(negedge clk);
      lows = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (hsync == 1'b0) lows++;
      end
      check_val("hs_degenerate", 32'(lows), 32'd0);
      check_val("no_set_disabled", 32'(irq_cause), 32'd0);

      // Frame counter wrap 255 -> 0, y wraps 7 -> 0 on frame_end
      for (int k = 0; k < 40000; k++) begin
         @(negedge clk);
         if (frame_end && (frame_cnt == 8'hff)) break;
      end
      check_val("fcnt_255", 32'(frame_cnt), 32'd255);
      check_val("fe_at_255", 32'(frame_end), 32'd1);
      check_val("y_last", 32'(y), 32'd7);
      @(negedge clk);
      check_val("fcnt_wrap0", 32'(frame_cnt), 32'd0);
      check_val("y_wrap0", 32'(y), 32'd0);
      check_val("x_wrap0", 32'(x), 32'd0);

      // Async reset mid-line; a pending H_TOTAL write must be lost
      cfg_write(4'd3, 11'd9);
      wait_xy("wait_5_2", 5, 2, 100);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_x", 32'(x), 32'd0);
      check_val("arst_y", 32'(y), 32'd0);
      check_val("arst_fcnt", 32'(frame_cnt), 32'd0);
      check_val("arst_hsync", 32'(hsync), 32'd0);
      check_val("arst_cause", 32'(irq_cause), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_line(n, 100);
      check_val("def_h_total", 32'(x), 32'd55);
      count_line(n, 100);
      check_val("def_line_period", 32'(n), 32'd56);
      wait_frame_end("fe_after_rst", 2000);
      check_val("def_v_total2", 32'(y), 32'd29);
      count_line(n, 100);
      check_val("pending_lost", 32'(n), 32'd56);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
